// File: rtl/hwpe_stream_merge_stride_if.sv
// Multi-lane HWPE-Stream bundle: NB_LANES independent valid/ready channels,
// packed so a narrow-lane group or a single wide stream share one definition.
interface hwpe_stream_merge_stride_if #(
  parameter int unsigned NB_LANES   = 1,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [NB_LANES-1:0][DATA_WIDTH-1:0]   data;
  logic [NB_LANES-1:0][DATA_WIDTH/8-1:0] strb;
  logic [NB_LANES-1:0]                   valid;
  logic [NB_LANES-1:0]                   ready;

  modport master (output data, strb, valid, input  ready);
  modport slave  (input  data, strb, valid, output ready);
endinterface

// File: rtl/hwpe_stream_merge_stride.sv
// Joins NB_IN_STREAMS narrow strided lanes into one wide stream, restoring
// element k = lane + elem*NB_IN_STREAMS; lanes are captured independently.
module hwpe_stream_merge_stride_lane #(
  parameter int unsigned DW = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  input  logic [DW/8-1:0] push_strb,
  input  logic          load,
  output logic          push_ready,
  output logic          lane_full,
  output logic [DW-1:0] lane_data,
  output logic [DW/8-1:0] lane_strb
);
  logic capture;

  // A full lane can still accept when its beat leaves in this same cycle.
  assign push_ready = !lane_full || load;
  assign capture    = push_valid && push_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lane_full <= 1'b0;
      lane_data <= '0;
      lane_strb <= '0;
    end else if (capture) begin
      lane_full <= 1'b1;
      lane_data <= push_data;
      lane_strb <= push_strb;
    end else if (load) begin
      lane_full <= 1'b0;
    end
  end
endmodule

module hwpe_stream_merge_stride #(
  parameter int unsigned NB_IN_STREAMS  = 4,
  parameter int unsigned DATA_WIDTH_OUT = 256,
  parameter int unsigned ELEMENT_WIDTH  = 16
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clear_i,
  hwpe_stream_merge_stride_if.slave  push_i,
  hwpe_stream_merge_stride_if.master pop_o,
  output logic [31:0] beat_cnt_o
);
  localparam int unsigned DATA_WIDTH_IN  = DATA_WIDTH_OUT / NB_IN_STREAMS;
  localparam int unsigned ELEMS_PER_LANE = DATA_WIDTH_IN / ELEMENT_WIDTH;
  localparam int unsigned ELEM_BYTES     = ELEMENT_WIDTH / 8;

  if (DATA_WIDTH_OUT % (NB_IN_STREAMS*ELEMENT_WIDTH) != 0 || ELEMENT_WIDTH % 8 != 0) begin : g_bad_params
    $error("hwpe_stream_merge_stride: unsupported width parameters");
  end

  logic [NB_IN_STREAMS-1:0]                      lane_full, lane_ready;
  logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN-1:0]   lane_data;
  logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN/8-1:0] lane_strb;
  logic [DATA_WIDTH_OUT-1:0]   wide_data, out_data;
  logic [DATA_WIDTH_OUT/8-1:0] wide_strb, out_strb;
  logic all_full, load, out_valid, out_fire;

  assign all_full = &lane_full;
  assign out_fire = out_valid && pop_o.ready[0];
  assign load     = all_full && (!out_valid || pop_o.ready[0]);

  for (genvar ii = 0; ii < NB_IN_STREAMS; ii++) begin : g_lane
    hwpe_stream_merge_stride_lane #(.DW(DATA_WIDTH_IN)) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .push_valid (push_i.valid[ii]),
      .push_data  (push_i.data[ii]),
      .push_strb  (push_i.strb[ii]),
      .load       (load),
      .push_ready (lane_ready[ii]),
      .lane_full  (lane_full[ii]),
      .lane_data  (lane_data[ii]),
      .lane_strb  (lane_strb[ii])
    );
  end

  assign push_i.ready = lane_ready;

  always_comb begin
    wide_data = '0;
    wide_strb = '0;
    for (int unsigned ii = 0; ii < NB_IN_STREAMS; ii++) begin
      for (int unsigned jj = 0; jj < ELEMS_PER_LANE; jj++) begin
        wide_data[(ii + jj*NB_IN_STREAMS)*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
          lane_data[ii][jj*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        wide_strb[(ii + jj*NB_IN_STREAMS)*ELEM_BYTES +: ELEM_BYTES] =
          lane_strb[ii][jj*ELEM_BYTES +: ELEM_BYTES];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_strb   <= '0;
      beat_cnt_o <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= wide_data;
        out_strb  <= wide_strb;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_fire) beat_cnt_o <= beat_cnt_o + 32'd1;
    end
  end

  assign pop_o.valid[0] = out_valid;
  assign pop_o.data[0]  = out_data;
  assign pop_o.strb[0]  = out_strb;
endmodule

// File: tb/tb_hwpe_stream_merge_stride.sv
// Randomized + directed bench for hwpe_stream_merge_stride against a queue-based model.
module tb_hwpe_stream_merge_stride;
  localparam int N = 4, DWO = 256, EW = 16, DWI = DWO/N, SI = DWI/8, SO = DWO/8;
  localparam int EPL = DWI/EW, EB = EW/8;

  logic clk = 1'b0, rst, clear;
  logic [31:0] beat_cnt;
  always #5 clk = ~clk;

  hwpe_stream_merge_stride_if #(.NB_LANES(N), .DATA_WIDTH(DWI)) push ();
  hwpe_stream_merge_stride_if #(.NB_LANES(1), .DATA_WIDTH(DWO)) pop ();

  hwpe_stream_merge_stride #(.NB_IN_STREAMS(N), .DATA_WIDTH_OUT(DWO), .ELEMENT_WIDTH(EW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .push_i(push), .pop_o(pop), .beat_cnt_o(beat_cnt));

  typedef struct packed { logic [DWI-1:0] d; logic [SI-1:0] s; } lbeat_t;
  typedef struct packed { logic [DWO-1:0] d; logic [SO-1:0] s; } wbeat_t;

  lbeat_t lq[N][$];
  wbeat_t oq[$];
  lbeat_t din[N];
  logic [31:0] m_cnt;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Wide element k comes from lane k%N, element k/N of that lane's oldest beat.
  function automatic wbeat_t merge_fronts();
    wbeat_t w;
    w = '0;
    for (int k = 0; k < N*EPL; k++) begin
      w.d[k*EW +: EW] = lq[k % N][0].d[(k / N)*EW +: EW];
      for (int b = 0; b < EB; b++) w.s[k*EB + b] = lq[k % N][0].s[(k / N)*EB + b];
    end
    return w;
  endfunction

  task automatic rand_din();
    for (int i = 0; i < N; i++) begin
      din[i].d = {$urandom, $urandom};
      din[i].s = SI'($urandom);
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic clr, input logic rs,
                       output logic [N-1:0] cap);
    logic [N-1:0] rdy_exp;
    bit load, allf;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      push.valid[i] = v[i];
      push.data[i]  = din[i].d;
      push.strb[i]  = din[i].s;
    end
    pop.ready[0] = rdy;
    clear = clr;
    rst = rs;
    #1;
    allf = 1;
    for (int i = 0; i < N; i++) if (lq[i].size() == 0) allf = 0;
    load = allf && (oq.size() == 0 || rdy);
    for (int i = 0; i < N; i++) rdy_exp[i] = (lq[i].size() == 0) || load;
    chk("push_ready", 256'(push.ready), 256'(rdy_exp));
    chk("pop_valid", 256'(pop.valid[0]), 256'(oq.size() != 0));
    if (oq.size() != 0) begin
      chk("pop_data", pop.data[0], oq[0].d);
      chk("pop_strb", 256'(pop.strb[0]), 256'(oq[0].s));
    end
    chk("beat_cnt", 256'(beat_cnt), 256'(m_cnt));
    cap = '0;
    if (clr || rs) begin
      for (int i = 0; i < N; i++) lq[i].delete();
      oq.delete();
      m_cnt = 0;
    end else begin
      if (oq.size() != 0 && rdy) begin
        void'(oq.pop_front());
        m_cnt++;
      end
      if (load) begin
        oq.push_back(merge_fronts());
        for (int i = 0; i < N; i++) void'(lq[i].pop_front());
      end
      for (int i = 0; i < N; i++)
        if (v[i] && rdy_exp[i]) begin
          lq[i].push_back(din[i]);
          cap[i] = 1'b1;
        end
    end
  endtask

  logic [N-1:0] cp;
  int sent[N];
  wbeat_t w1;
  logic [31:0] cnt0;

  initial begin
    rst = 1'b1; clear = 1'b0; m_cnt = 0;
    push.valid = '0; push.data = '0; push.strb = '0; pop.ready = '0;
    for (int i = 0; i < N; i++) din[i] = '0;
    repeat (2) @(posedge clk);

    // basic merge with recognisable element values
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < EPL; j++) din[i].d[j*EW +: EW] = 16'(16*i + j);
      din[i].s = 8'hFF;
    end
    cycle('1, 1, 0, 0, cp);
    cycle('0, 1, 0, 0, cp);
    cycle('0, 1, 0, 0, cp);
    chk("t1_valid", 256'(pop.valid[0]), 256'(1));
    chk("t1_elems_0_7", 256'(pop.data[0][127:0]), 256'(128'h0031_0021_0011_0001_0030_0020_0010_0000));
    chk("t1_elems_12_15", 256'(pop.data[0][255:192]), 256'(64'h0033_0023_0013_0003));
    chk("t1_strb", 256'(pop.strb[0]), 256'(32'hFFFF_FFFF));
    cycle('0, 1, 0, 0, cp);
    chk("t1_cnt", 256'(beat_cnt), 256'(1));

    // strobe mapping with lane 1 fully disabled
    rand_din();
    for (int i = 0; i < N; i++) din[i].s = (i == 1) ? 8'h00 : 8'hFF;
    cycle('1, 1, 0, 0, cp);
    cycle('0, 1, 0, 0, cp);
    cycle('0, 1, 0, 0, cp);
    chk("t2_strb", 256'(pop.strb[0]), 256'(32'hF3F3_F3F3));

    // skewed lanes
    cycle('0, 1, 0, 0, cp);
    cnt0 = beat_cnt;
    rand_din();
    cycle(4'b0011, 1, 0, 0, cp);
    cycle(4'b0000, 1, 0, 0, cp);
    cycle(4'b0000, 1, 0, 0, cp);
    cycle(4'b0100, 1, 0, 0, cp);
    cycle(4'b0000, 1, 0, 0, cp);
    cycle(4'b1000, 1, 0, 0, cp);
    chk("t3_early_ready", 256'(push.ready[1:0]), 256'(0));
    cycle(4'b0000, 1, 0, 0, cp);
    chk("t3_not_yet", 256'(pop.valid[0]), 256'(0));
    cycle(4'b0000, 1, 0, 0, cp);
    chk("t3_valid", 256'(pop.valid[0]), 256'(1));
    cycle(4'b0000, 1, 0, 0, cp);
    cycle(4'b0000, 1, 0, 0, cp);
    chk("t3_one_beat", 256'(beat_cnt - cnt0), 256'(1));

    // streaming with a 3-cycle output stall
    cycle('0, 1, 1, 0, cp);
    for (int i = 0; i < N; i++) sent[i] = 0;
    for (int c = 0; c < 20; c++) begin
      logic [N-1:0] v;
      rand_din();
      for (int i = 0; i < N; i++) v[i] = sent[i] < 8;
      cycle(v, !(c >= 3 && c <= 5), 0, 0, cp);
      for (int i = 0; i < N; i++) if (cp[i]) sent[i]++;
    end
    chk("t4_cnt", 256'(beat_cnt), 256'(8));

    // clear with partial lanes and an un-popped output beat
    rand_din();
    cycle('1, 0, 0, 0, cp);
    cycle('0, 0, 0, 0, cp);
    rand_din();
    cycle(4'b0101, 0, 0, 0, cp);
    cycle('0, 0, 1, 0, cp);
    cycle('0, 1, 0, 0, cp);
    chk("t5_valid", 256'(pop.valid[0]), 256'(0));
    chk("t5_ready", 256'(push.ready), 256'(4'hF));
    chk("t5_cnt", 256'(beat_cnt), 256'(0));
    rand_din();
    cycle('1, 1, 0, 0, cp);
    cycle('0, 1, 0, 0, cp);
    cycle('0, 1, 0, 0, cp);

    // load and capture in the same cycle
    rand_din();
    cycle('1, 1, 0, 0, cp);
    w1 = merge_fronts();
    rand_din();
    cycle('1, 1, 0, 0, cp);
    chk("t6_ready", 256'(push.ready), 256'(4'hF));
    cycle('0, 0, 0, 0, cp);
    chk("t6_old_beat", pop.data[0], w1.d);
    chk("t6_lanes_held", 256'(push.ready), 256'(0));
    cycle('0, 1, 0, 0, cp);
    cycle('0, 1, 0, 0, cp);

    // random traffic with occasional clear / reset
    for (int c = 0; c < 600; c++) begin
      rand_din();
      cycle(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 149) == 0, cp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hwpe_stream_merge_stride.md
Name: hwpe_stream_merge_stride

Overview:
Inverse of the strided stream splitter. It joins NB_IN_STREAMS narrow HWPE-Stream inputs into one wide output stream, de-interleaving elements back into their original wide positions. Each input lane is captured independently, so lanes may arrive skewed. One wide beat is emitted through a registered output stage once every lane holds data. It sits on the TCDM load side, between the per-port 32-bit-class streams and the wide HWPE datapath.

Parameters:
NB_IN_STREAMS, 4, number of narrow input streams.
DATA_WIDTH_OUT, 256, width of the merged output stream.
ELEMENT_WIDTH, 16, element size in bits; must be a multiple of 8.
DATA_WIDTH_IN (derived), DATA_WIDTH_OUT/NB_IN_STREAMS, width of each input lane.
ELEMS_PER_LANE (derived), DATA_WIDTH_IN/ELEMENT_WIDTH, elements carried by each lane.
ELEM_BYTES (derived), ELEMENT_WIDTH/8, bytes per element.

Ports:
clk_i  in  1  clock; the only clock.
rst_i  in  1  reset; synchronous, active-high.
clear_i  in  1  synchronous soft clear; same effect as rst_i.
push_i[NB_IN_STREAMS-1:0]  sink  DATA_WIDTH_IN data / DATA_WIDTH_IN/8 strb / valid / ready  narrow input lanes.
pop_o  source  DATA_WIDTH_OUT data / DATA_WIDTH_OUT/8 strb / valid / ready  merged wide output.
beat_cnt_o  out  32  count of wide beats emitted; wraps modulo 2^32.

Behaviour:
- Mapping: lane ii, element jj goes to wide element k = ii + jj*NB_IN_STREAMS. Byte b of that element (b < ELEM_BYTES) goes to wide strb bit k*ELEM_BYTES + b; it takes lane strb bit jj*ELEM_BYTES + b.
- Per-lane holding register: lane_data[ii], lane_strb[ii], lane_full[ii].
- all_full = AND of lane_full.
- load = all_full && (!pop_o.valid || pop_o.ready).
- Lane handshake:
  - push_i[ii].ready = !lane_full[ii] || load. This is combinational from registers and pop_o.ready only; it never depends on push valid.
  - Capture happens when push_i[ii].valid && push_i[ii].ready. Data and strb are latched and lane_full[ii] is set.
  - On load without a capture in the same cycle, lane_full[ii] clears.
  - On load with a simultaneous capture, lane_full[ii] stays 1 and holds the new data.
- Output stage:
  - On load, the permuted lane contents go to pop_o.data/strb and pop_o.valid is set.
  - Otherwise, if pop_o.valid && pop_o.ready, pop_o.valid clears.
  - While valid && !ready, data and strb are held stable.
- beat_cnt_o increments on every pop_o.valid && pop_o.ready.
- Latency: the last lane captured at edge t gives pop_o.valid = 1 after edge t+1 (2 cycles from push handshake to output).
- Throughput: one wide beat per cycle when all lanes are valid every cycle and pop_o.ready stays 1.
- Skew: an early lane holds its beat and drops ready until all lanes have a beat. No lane ever holds more than one beat, so beat ordering is preserved per lane.
- Backpressure:
  - pop_o.ready = 0 with output valid and all lanes full: load = 0 and every push ready = 0.
  - Capacity is one output beat plus one beat per lane.
- Reset/clear (rst_i or clear_i high at an edge):
  - lane_full = 0, lane_data/strb = 0, pop_o.valid = 0, pop_o.data = 0, pop_o.strb = 0, beat_cnt_o = 0.
  - Any in-flight beats are discarded.
  - In that cycle push ready is still computed from the current registers, but captures are discarded.
  - rst_i/clear_i takes priority over every other update.
- Elaboration fails if DATA_WIDTH_OUT % (NB_IN_STREAMS*ELEMENT_WIDTH) != 0 or ELEMENT_WIDTH % 8 != 0.

Test Plan:
1. Basic merge (defaults):
   - Stimulus: after reset, all 4 lanes valid for one cycle. Lane ii element jj = 0x10*ii + jj, all strb = 0xFF.
   - Required: pop_o.valid rises 2 cycles later. Wide elements 0..7 = 0x00,0x10,0x20,0x30,0x01,0x11,0x21,0x31; elements 12..15 = 0x03,0x13,0x23,0x33. Strb = 0xFFFFFFFF. beat_cnt_o = 1 after the pop.
2. Strobe mapping:
   - Stimulus: lane 1 strb = 0x00, lanes 0/2/3 strb = 0xFF.
   - Required: pop_o.strb = 0xF3F3F3F3.
3. Skew:
   - Stimulus: lanes 0,1 valid at cycle 0; lane 2 at cycle 3; lane 3 at cycle 5.
   - Required: lanes 0,1 ready = 0 during cycles 1-5; exactly one output beat, valid after cycle 6. No beat is duplicated or dropped.
4. Streaming and backpressure:
   - Stimulus: 8 consecutive beats with all lanes valid; pop_o.ready low for cycles 3-5.
   - Required: 1 beat/cycle outside the stall; output is held stable during the stall. All 8 beats arrive in order with correct permutation, and beat_cnt_o = 8.
5. Clear mid-operation:
   - Stimulus: lanes 0,2 captured and the output holds an un-popped beat; assert clear_i for 1 cycle.
   - Required: next cycle pop_o.valid = 0, all push ready = 1, beat_cnt_o = 0. The next full set of lanes produces only the new data.
6. Simultaneous load and capture:
   - Stimulus: all lanes full, output empty, all lanes valid again.
   - Required: the old beat moves to the output and the new beats are captured in the same cycle. The lanes remain full with the new data.
